road_scroller: RTL
==================

# road_scroller

Playfield buffer for the car-dash game, directly downstream of the random obstacle-sequence generator. It accepts each 16-bit obstacle sequence as two 8-lane rows and queues them. On every scroll tick it shifts a ROWS-deep playfield down one row, checks the bottom row against the car's lane, and maintains score and crash state for the display and control logic.

## Interface
- ROWS, 8, playfield depth in rows (≥2)
- GAP_ROWS, 2, wall-only rows inserted after each sequence's second row (0–15)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins or restarts a game
- tick  in  1  one-cycle scroll-step pulse
- seq_in  in  16  obstacle sequence; bit i = generator sequence bit i
- seq_load  in  1  one-cycle pulse; seq_in valid
- car_lane  in  3  car lane index 0–7
- field  out  ROWS*8  row r occupies bits [8r+7:8r]; row 0 top, row ROWS-1 bottom; lane i = bit i
- seq_req  out  1  high while pending buffer empty
- running  out  1  state == RUN
- crash  out  1  state == CRASH
- score  out  16  rows survived, saturating
- overrun  out  1  sticky; seq_load arrived while buffer non-empty

## Operation
- Row format: lanes 0 and 7 are walls and are always 1 in every row written to field; wall-only row = 8'h81.
- Sequence split: row A = seq_in[7:0], row B = seq_in[15:8]; each ORed with 8'h81 on capture.
- Pending buffer: 2 entries, A emitted first. seq_load is accepted only if buffer empty at start of cycle; else dropped and overrun set (cleared only by rst or start).
- Gap counter: loaded with GAP_ROWS when row B is emitted. While nonzero, each tick emits 8'h81 and decrements. Pending rows are not emitted until counter = 0.
- Top-row source on scroll: pending head if buffer non-empty and gap = 0; else 8'h81.
- FSM:
  - IDLE: field all 8'h81, score 0. start → RUN. tick ignored. seq_load accepted.
  - RUN: on tick, field[r] ← field[r-1] for r ≥ 1; field[0] ← source row. After the shift, if (new bottom row & (1<<car_lane)) ≠ 0 → CRASH, score unchanged; else score +1 (saturates at 16'hFFFF). start ignored.
  - CRASH: field, score frozen; tick and car_lane ignored; seq_load still accepted. start → RUN, with field reset to all 8'h81, score 0, gap 0, overrun 0; pending buffer kept.
- car_lane 0 or 7 collides with a wall on the next tick.

## Timing
- Reset values: field all 8'h81, score 0, running 0, crash 0, overrun 0, seq_req 1, buffer empty, gap 0, state IDLE.
- rst has priority over every input in the same cycle, including mid-RUN.
- All outputs are registered. Effects of a tick at edge N (field shift, score, crash/running) are visible after edge N.
- seq_req deasserts the cycle after an accepted seq_load. It reasserts the cycle after the tick that emits row B.
- Simultaneous tick and seq_load, buffer empty: the tick emits 8'h81 (or consumes a gap step); the load is captured. The new row A is eligible on the next tick.
- Simultaneous tick and seq_load, buffer holding only B: the tick emits B; the load is rejected (overrun=1) because the buffer is non-empty at cycle start.
- Simultaneous start and tick in IDLE or CRASH: the state transition takes effect and the tick is ignored.
- Collision uses car_lane sampled at the tick edge.

## Test plan
- Reset/idle: assert rst 1 cycle → field all 8'h81, seq_req=1, score=0, running=0. Apply 5 ticks in IDLE → no change.
- Load and scroll: seq_load with seq_in=16'h0000; start; car_lane=3; apply 9 ticks → row 0 = 81 for every tick after the first two. After tick 8, row A reaches row 7 with bit 3 clear. Score=9, no crash.
- Collision: seq_in=16'h0010 (row A lane 4); start; car_lane=4; apply ticks → crash=1 on tick 8, score=7, field frozen on later ticks.
- Gap: two sequences (second loaded when seq_req rises); GAP_ROWS=2 → rows A, B, 81, 81 precede the second sequence's A at the top row.
- Overrun/simultaneous: tick and seq_load in the same cycle with only B pending → B emitted, overrun=1. A following start clears overrun.
- Restart and reset: in CRASH, pulse start → field all 8'h81, score 0, running=1. Assert rst mid-RUN → all reset values next cycle.

Source files
------------

// File: rtl/road_scroller.sv
// road_scroller: playfield buffer for the car-dash game.
// Captures 16-bit obstacle sequences as two 8-lane rows into a 2-entry pending
// buffer, scrolls a ROWS-deep playfield one row per tick, detects collisions of
// the bottom row with the car lane, and keeps score / crash / overrun state.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse, begins or restarts a game (IDLE/CRASH only)
//   tick      one-cycle scroll-step pulse (acted on in RUN only)
//   seq_in    obstacle sequence; row A = [7:0], row B = [15:8]
//   seq_load  one-cycle pulse, seq_in valid
//   car_lane  car lane index 0-7
//   field     playfield; row r at bits [8r+7:8r], row 0 top
//   seq_req   high while pending buffer is empty
//   running   game in RUN
//   crash     game in CRASH
//   score     rows survived, saturating
//   overrun   sticky; seq_load dropped because buffer was non-empty
module road_scroller #(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned GAP_ROWS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              tick,
   input  logic [15:0]       seq_in,
   input  logic              seq_load,
   input  logic [2:0]        car_lane,
   output logic [ROWS*8-1:0] field,
   output logic              seq_req,
   output logic              running,
   output logic              crash,
   output logic [15:0]       score,
   output logic              overrun
);

   localparam logic [7:0] WallRow = 8'h81;
   localparam logic [3:0] GapInit = 4'(GAP_ROWS);

   typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

   state_e             state_q, state_d;
   logic [ROWS*8-1:0]  field_q, field_d;
   logic [15:0]        score_q, score_d;
   logic [7:0]         row_a_q, row_a_d;
   logic [7:0]         row_b_q, row_b_d;
   logic [1:0]         cnt_q, cnt_d;     // pending rows: 2 = A and B, 1 = B only
   logic [3:0]         gap_q, gap_d;
   logic               overrun_q, overrun_d;
   logic [7:0]         src_row;
   logic [7:0]         new_bottom;

   always_comb begin
      state_d    = state_q;
      field_d    = field_q;
      score_d    = score_q;
      row_a_d    = row_a_q;
      row_b_d    = row_b_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      overrun_d  = overrun_q;
      src_row    = WallRow;
      new_bottom = field_q[8*(ROWS-1)-1 -: 8];

      case (state_q)
         StIdle, StCrash: begin
            if (start) begin
               state_d   = StRun;
               field_d   = {ROWS{WallRow}};
               score_d   = 16'd0;
               gap_d     = 4'd0;
               overrun_d = 1'b0;
            end
         end
         StRun: begin
            if (tick) begin
               if (cnt_q != 2'd0 && gap_q == 4'd0) begin
                  src_row = (cnt_q == 2'd2) ? row_a_q : row_b_q;
                  cnt_d   = cnt_q - 2'd1;
                  // Emitting row B opens the wall-only gap before the next sequence.
                  if (cnt_q == 2'd1) gap_d = GapInit;
               end else if (gap_q != 4'd0) begin
                  gap_d = gap_q - 4'd1;
               end
               field_d = {field_q[8*(ROWS-1)-1:0], src_row};
               // The row shifting into the bottom slot is the old row ROWS-2.
               if (new_bottom[car_lane]) begin
                  state_d = StCrash;
               end else if (score_q != 16'hFFFF) begin
                  score_d = score_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Buffer occupancy is judged at cycle start, so a same-cycle pop never frees room.
      if (seq_load) begin
         if (cnt_q == 2'd0) begin
            row_a_d = seq_in[7:0] | WallRow;
            row_b_d = seq_in[15:8] | WallRow;
            cnt_d   = 2'd2;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         field_q   <= {ROWS{WallRow}};
         score_q   <= 16'd0;
         row_a_q   <= WallRow;
         row_b_q   <= WallRow;
         cnt_q     <= 2'd0;
         gap_q     <= 4'd0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         field_q   <= field_d;
         score_q   <= score_d;
         row_a_q   <= row_a_d;
         row_b_q   <= row_b_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         overrun_q <= overrun_d;
      end
   end

   assign field   = field_q;
   assign score   = score_q;
   assign overrun = overrun_q;
   assign seq_req = (cnt_q == 2'd0);
   assign running = (state_q == StRun);
   assign crash   = (state_q == StCrash);

endmodule
